// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: gates the CPU clock-enable for a bounded run, then reads a
// block of registers through the register-file read port and streams them out
// over a valid/ready dump interface.
module cpu_run_monitor #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_DUMP   = 12,
  parameter int END_COUNT  = 5,
  parameter int IDLE_LIMIT = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic                  stop_i,
  input  logic [DATA_W-1:0]     pc_i,
  output logic                  cpu_run_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0]     rf_data_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [REG_ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0]     dump_data_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic [1:0]            halt_cause_o,
  output logic                  done_o
);

  localparam int IDLE_W = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(END_COUNT - 1);
  localparam logic [REG_ADDR_W-1:0] DUMP_LAST = REG_ADDR_W'(NUM_DUMP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            mode_q;
  logic [DATA_W-1:0]     prev_pc_q;
  logic                  pc_hist_q;
  logic [IDLE_W-1:0]     idle_cnt_q;
  logic [CNT_W-1:0]      cycle_cnt_q;
  logic [1:0]            cause_q;
  logic [1:0]            cause_d;
  logic                  done_q;
  logic [REG_ADDR_W-1:0] rf_addr_q;
  logic [REG_ADDR_W-1:0] dump_idx_q;
  logic [DATA_W-1:0]     dump_data_q;
  logic                  dump_valid_q;
  logic                  pc_eq;
  logic                  stop_ext;
  logic                  stop_cnt;
  logic                  stop_idle;
  logic                  stop_any;

  // Stop detection and next-state selection; halt cause priority ext > count > idle
  always_comb begin
    state_d   = state_q;
    pc_eq     = pc_hist_q && (pc_i == prev_pc_q);
    stop_ext  = stop_i;
    stop_cnt  = ((mode_q == 2'b00) || (mode_q == 2'b10)) && (cycle_cnt_q == CNT_LAST);
    stop_idle = ((mode_q == 2'b01) || (mode_q == 2'b10)) && pc_eq && (idle_cnt_q == IDLE_LAST);
    stop_any  = stop_ext || stop_cnt || stop_idle;
    cause_d   = 2'b00;
    if (stop_ext) begin
      cause_d = 2'b11;
    end else if (stop_cnt) begin
      cause_d = 2'b01;
    end else if (stop_idle) begin
      cause_d = 2'b10;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_any) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (dump_valid_q && dump_ready_i) begin
          state_d = (dump_idx_q == DUMP_LAST) ? ST_DONE : ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run bookkeeping (cycle/idle counters, halt cause) and the dump datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= 2'b00;
      prev_pc_q    <= '0;
      pc_hist_q    <= 1'b0;
      idle_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      cause_q      <= 2'b00;
      done_q       <= 1'b0;
      rf_addr_q    <= '0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cycle_cnt_q <= '0;
            cause_q     <= 2'b00;
            done_q      <= 1'b0;
            mode_q      <= mode_i;
            pc_hist_q   <= 1'b0;
            idle_cnt_q  <= '0;
          end
        end
        ST_RUN: begin
          cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
          prev_pc_q   <= pc_i;
          pc_hist_q   <= 1'b1;
          if (pc_eq) begin
            idle_cnt_q <= (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
          end else begin
            idle_cnt_q <= '0;
          end
          if (stop_any) begin
            cause_q    <= cause_d;
            rf_addr_q  <= '0;
            dump_idx_q <= '0;
          end
        end
        ST_LOAD: begin
          dump_data_q  <= rf_data_i;
          dump_valid_q <= 1'b1;
        end
        ST_SEND: begin
          if (dump_valid_q && dump_ready_i) begin
            dump_valid_q <= 1'b0;
            if (dump_idx_q == DUMP_LAST) begin
              done_q <= 1'b1;
            end else begin
              rf_addr_q  <= rf_addr_q + REG_ADDR_W'(1);
              dump_idx_q <= dump_idx_q + REG_ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_run_o    = (state_q == ST_RUN);
  assign rf_addr_o    = rf_addr_q;
  assign dump_valid_o = dump_valid_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign halt_cause_o = cause_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: scoreboard bench for the run-and-dump controller with a
// behavioural register file and a sink that can stall on one dump index.
module tb_cpu_run_monitor;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_DUMP   = 12;
  localparam int END_COUNT  = 5;
  localparam int IDLE_LIMIT = 4;
  localparam int CNT_W      = 32;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  start_i = 1'b0;
  logic [1:0]            mode_i = 2'b00;
  logic                  stop_i = 1'b0;
  logic [DATA_W-1:0]     pc_i = '0;
  logic                  cpu_run_o;
  logic [REG_ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0]     rf_data_i;
  logic                  dump_valid_o;
  logic                  dump_ready_i = 1'b1;
  logic [REG_ADDR_W-1:0] dump_idx_o;
  logic [DATA_W-1:0]     dump_data_o;
  logic [CNT_W-1:0]      cycle_cnt_o;
  logic [1:0]            halt_cause_o;
  logic                  done_o;

  logic [DATA_W-1:0] rf [32];
  logic [REG_ADDR_W+DATA_W-1:0] exp_q [$];

  int compared_cnt = 0;
  int mismatch_cnt = 0;
  int stall_left = 0;
  bit hold_pend = 1'b0;
  int gap_stage = 0;
  logic [REG_ADDR_W-1:0] hold_idx;
  logic [DATA_W-1:0]     hold_data;
  logic [REG_ADDR_W-1:0] last_idx;

  cpu_run_monitor #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_DUMP(NUM_DUMP),
    .END_COUNT(END_COUNT), .IDLE_LIMIT(IDLE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .stop_i(stop_i), .pc_i(pc_i), .cpu_run_o(cpu_run_o), .rf_addr_o(rf_addr_o),
    .rf_data_i(rf_data_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .cycle_cnt_o(cycle_cnt_o),
    .halt_cause_o(halt_cause_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  assign rf_data_i = rf[rf_addr_o];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sink: drops ready for stall_left cycles while index 5 is offered
  always @(posedge clk_i) begin
    #1;
    if (stall_left > 0 && dump_valid_o && dump_idx_o == 5) begin
      dump_ready_i = 1'b0;
      stall_left--;
    end else begin
      dump_ready_i = 1'b1;
    end
  end

  // Dump monitor: pops the scoreboard on each handshake and checks hold/gap rules
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold_pend = 1'b0;
      gap_stage = 0;
    end else begin
      if (hold_pend) begin
        checkOutput("hold_valid", 64'(dump_valid_o), 64'd1);
        checkOutput("hold_idx", 64'(dump_idx_o), 64'(hold_idx));
        checkOutput("hold_data", 64'(dump_data_o), 64'(hold_data));
        hold_pend = 1'b0;
      end
      if (gap_stage == 1) begin
        checkOutput("gap_valid", 64'(dump_valid_o), 64'd0);
        gap_stage = (last_idx == REG_ADDR_W'(NUM_DUMP - 1)) ? 0 : 2;
      end else if (gap_stage == 2) begin
        checkOutput("next_valid", 64'(dump_valid_o), 64'd1);
        checkOutput("next_idx", 64'(dump_idx_o), 64'(last_idx) + 64'd1);
        gap_stage = 0;
      end
      if (dump_valid_o && !dump_ready_i) begin
        hold_pend = 1'b1;
        hold_idx  = dump_idx_o;
        hold_data = dump_data_o;
      end
      if (dump_valid_o && dump_ready_i) begin
        checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [REG_ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          checkOutput("dump_idx", 64'(dump_idx_o), 64'(e[REG_ADDR_W+DATA_W-1:DATA_W]));
          checkOutput("dump_data", 64'(dump_data_o), 64'(e[DATA_W-1:0]));
        end
        last_idx  = dump_idx_o;
        gap_stage = 1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] pcFor(input int kind, input int k);
    if (kind == 1) begin
      return (k < 4) ? (32'h10 + 32'(4 * k)) : 32'h20;
    end
    return 32'h100 + 32'(4 * k);
  endfunction

  // Fresh RF snapshot, expected dump words queued, one-cycle start pulse
  task automatic applyStimulus(input logic [1:0] mode);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
    end
    for (int i = 0; i < NUM_DUMP; i++) begin
      exp_q.push_back({REG_ADDR_W'(i), rf[i]});
    end
    mode_i  = mode;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    mode_i  = ~mode;
  endtask

  // Drives PC/stop per RUN cycle and counts cycles with cpu_run_o high
  task automatic runPhase(input int kind, input int stop_at, input bit pulse_start, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      pc_i    = pcFor(kind, k);
      stop_i  = (k == stop_at);
      start_i = pulse_start && (k == 1);
      @(negedge clk_i);
      if (k == 0) begin
        checkOutput("done_low_in_run", 64'(done_o), 64'd0);
      end
      if (!cpu_run_o) begin
        break;
      end
      n++;
      @(posedge clk_i);
      #1;
    end
    stop_i  = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic waitDone(output int d);
    d = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin
        break;
      end
      d++;
      @(negedge clk_i);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_run"}, 64'(cpu_run_o), 64'd0);
    checkOutput({tag, "_valid"}, 64'(dump_valid_o), 64'd0);
    checkOutput({tag, "_done"}, 64'(done_o), 64'd0);
    checkOutput({tag, "_cnt"}, 64'(cycle_cnt_o), 64'd0);
    checkOutput({tag, "_cause"}, 64'(halt_cause_o), 64'd0);
    checkOutput({tag, "_addr"}, 64'(rf_addr_o), 64'd0);
    checkOutput({tag, "_idx"}, 64'(dump_idx_o), 64'd0);
    checkOutput({tag, "_data"}, 64'(dump_data_o), 64'd0);
  endtask

  task automatic checkRunResult(input string tag, input int n, input int exp_n,
                                input int exp_cnt, input logic [1:0] exp_cause);
    checkOutput({tag, "_run_cycles"}, 64'(n), 64'(exp_n));
    checkOutput({tag, "_cycle_cnt"}, 64'(cycle_cnt_o), 64'(exp_cnt));
    checkOutput({tag, "_cause"}, 64'(halt_cause_o), 64'(exp_cause));
  endtask

  task automatic checkDump(input string tag, input int exp_d, input int exp_cnt,
                           input logic [1:0] exp_cause);
    int d;
    waitDone(d);
    checkOutput({tag, "_dump_cycles"}, 64'(d), 64'(exp_d));
    checkOutput({tag, "_done"}, 64'(done_o), 64'd1);
    checkOutput({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    checkOutput({tag, "_cnt_hold"}, 64'(cycle_cnt_o), 64'(exp_cnt));
    checkOutput({tag, "_cause_hold"}, 64'(halt_cause_o), 64'(exp_cause));
  endtask

  // Test sequence
  initial begin
    int n;
    bit found;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
    end
    repeat (3) @(posedge clk_i);
    #1;
    checkZeroOutputs("reset");
    rst_i = 1'b0;

    $display("[TB] count stop, mode 00");
    applyStimulus(2'b00);
    runPhase(0, -1, 1'b0, n);
    checkRunResult("count", n, 5, 5, 2'b01);
    checkDump("count", 24, 5, 2'b01);

    $display("[TB] PC-idle stop, mode 01");
    applyStimulus(2'b01);
    runPhase(1, -1, 1'b0, n);
    checkRunResult("idle", n, 9, 9, 2'b10);
    checkDump("idle", 24, 9, 2'b10);

    $display("[TB] ext and count together, mode 10, stalled sink on idx 5");
    stall_left = 3;
    applyStimulus(2'b10);
    runPhase(0, END_COUNT - 1, 1'b0, n);
    checkRunResult("ext", n, 5, 5, 2'b11);
    checkDump("ext", 27, 5, 2'b11);

    $display("[TB] reset during dump at idx 3");
    applyStimulus(2'b00);
    runPhase(0, -1, 1'b0, n);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (dump_valid_o && dump_idx_o == 3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach_idx3", 64'(found), 64'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkZeroOutputs("midreset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    applyStimulus(2'b00);
    runPhase(0, -1, 1'b0, n);
    checkRunResult("restart", n, 5, 5, 2'b01);
    checkDump("restart", 24, 5, 2'b01);

    $display("[TB] second start from DONE with start pulse during RUN");
    applyStimulus(2'b00);
    runPhase(0, -1, 1'b1, n);
    checkRunResult("rerun", n, 5, 5, 2'b01);
    checkDump("rerun", 24, 5, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
    $finish;
  end

endmodule
